// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC sequencer with direct-mapped BTB, in-flight prediction FIFO and mispredict redirect
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pred_taken,
  output logic [31:0] pc,
  output logic        fetch_fire,
  input  logic        res_valid,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_next_pc,
  output logic        redirect,
  output logic        upd_valid,
  output logic        upd_taken,
  output logic        fifo_full,
  output logic        res_err
);
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;
  localparam int FW = $clog2(FIFO_DEPTH);
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TW-1:0]          btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [31:0]            fifo_mem   [FIFO_DEPTH];
  logic [FW-1:0]          head, tail;
  logic [FW:0]            count, count_nxt;
  logic [IW-1:0]          lk_idx, wr_idx;
  logic [TW-1:0]          lk_tag, wr_tag;
  logic                   btb_hit, pop, btb_set, btb_clr, unused_bits;
  logic [31:0]            pred_next;
  assign unused_bits = ^res_pc[1:0];
  assign lk_idx      = pc[IW+1:2];
  assign lk_tag      = pc[31:IW+2];
  assign wr_idx      = res_pc[IW+1:2];
  assign wr_tag      = res_pc[31:IW+2];
  assign btb_hit     = btb_valid[lk_idx] && btb_tag[lk_idx] == lk_tag;
  assign pred_next   = (pred_taken && btb_hit) ? btb_target[lk_idx] : pc + 32'd4;
  assign pop         = res_valid && count != '0;
  assign redirect    = pop && fifo_mem[head] != res_next_pc;
  assign fetch_fire  = !stall && !fifo_full && !redirect;
  assign upd_valid   = res_valid && res_is_branch;
  assign upd_taken   = res_taken;
  assign btb_set     = pop && res_is_branch && res_taken;
  assign btb_clr     = pop && res_is_branch && !res_taken && btb_tag[wr_idx] == wr_tag;
  assign count_nxt   = count + (FW+1)'(fetch_fire) - (FW+1)'(pop);
  // fetch address: redirect beats a predicted advance, otherwise hold
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else if (redirect) pc <= res_next_pc;
    else if (fetch_fire) pc <= pred_next;
  // FIFO pointers and registered full flag; a redirect empties the buffer
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else if (redirect) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else begin
      head      <= pop ? head + FW'(1) : head;
      tail      <= fetch_fire ? tail + FW'(1) : tail;
      count     <= count_nxt;
      fifo_full <= count_nxt == (FW+1)'(FIFO_DEPTH);
    end
  // predicted next PCs awaiting resolution
  always_ff @(posedge clk)
    if (fetch_fire) fifo_mem[tail] <= pred_next;
  // sticky flag for a resolve arriving with nothing in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) res_err <= 1'b0;
    else if (res_valid && count == '0) res_err <= 1'b1;
  // BTB valid bits: taken branch allocates, not-taken with matching tag evicts
  always_ff @(posedge clk or posedge reset)
    if (reset) btb_valid <= '0;
    else if (btb_set) btb_valid[wr_idx] <= 1'b1;
    else if (btb_clr) btb_valid[wr_idx] <= 1'b0;
  // BTB tag and target payload, qualified by the valid bits
  always_ff @(posedge clk)
    if (btb_set) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= res_next_pc;
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed table, corner sequences and randomized run against a queue-based model
module tb_fetch_pc_unit;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b1, pred_taken = 1'b0;
  logic        res_valid = 1'b0, res_is_branch = 1'b0, res_taken = 1'b0;
  logic [31:0] res_pc = '0, res_next_pc = '0;
  logic [31:0] pc, w_pc;
  logic        fetch_fire, redirect, upd_valid, upd_taken, fifo_full, res_err;
  logic        w_stall = 1'b1, w_fire, w_redirect, w_uv, w_ut, w_full, w_err;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pred_taken(pred_taken), .pc(pc),
    .fetch_fire(fetch_fire), .res_valid(res_valid), .res_is_branch(res_is_branch),
    .res_taken(res_taken), .res_pc(res_pc), .res_next_pc(res_next_pc), .redirect(redirect),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .fifo_full(fifo_full), .res_err(res_err)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .stall(w_stall), .pred_taken(1'b0), .pc(w_pc),
    .fetch_fire(w_fire), .res_valid(1'b0), .res_is_branch(1'b0), .res_taken(1'b0),
    .res_pc(32'h0), .res_next_pc(32'h0), .redirect(w_redirect), .upd_valid(w_uv),
    .upd_taken(w_ut), .fifo_full(w_full), .res_err(w_err)
  );

  // reference model: queue of outstanding predictions and a keyed BTB
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_err;
  bit          bv[int];
  logic [31:0] bt[int];
  logic [31:0] bg[int];

  function automatic int bidx(logic [31:0] a);
    return int'((a / 32'd4) % 32'd16);
  endfunction

  function automatic logic [31:0] btag(logic [31:0] a);
    return a / 32'd64;
  endfunction

  function automatic bit bhit(logic [31:0] a);
    int i = bidx(a);
    return bv.exists(i) && bv[i] && bt[i] == btag(a);
  endfunction

  function automatic void mreset();
    m_pc = 32'h0;
    m_q.delete();
    m_err = 1'b0;
    bv.delete();
    bt.delete();
    bg.delete();
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  // drive one cycle at posedge+1, check combinational outputs, clock, check registers
  task automatic step(input bit st, pt, rv, rb, rt, input logic [31:0] rpc, rnp,
                      output bit o_fire, o_redir, o_uv, o_ut);
    bit          empty, mis, fire;
    logic [31:0] pn;
    int          wi;
    stall = st; pred_taken = pt; res_valid = rv; res_is_branch = rb; res_taken = rt;
    res_pc = rpc; res_next_pc = rnp;
    #2;
    o_fire = fetch_fire; o_redir = redirect; o_uv = upd_valid; o_ut = upd_taken;
    empty = m_q.size() == 0;
    pn    = (pt && bhit(m_pc)) ? bg[bidx(m_pc)] : m_pc + 32'd4;
    mis   = rv && !empty && m_q[0] != rnp;
    fire  = !st && m_q.size() != 4 && !mis;
    chk("fetch_fire", fetch_fire, fire);
    chk("redirect", redirect, mis);
    chk("upd_valid", upd_valid, rv && rb);
    chk("upd_taken", upd_taken, rt);
    if (rv && empty) m_err = 1'b1;
    wi = bidx(rpc);
    if (rv && !empty && rb) begin
      if (rt) begin
        bv[wi] = 1'b1; bt[wi] = btag(rpc); bg[wi] = rnp;
      end else if (bt.exists(wi) && bt[wi] == btag(rpc)) bv[wi] = 1'b0;
    end
    if (mis) begin
      m_q.delete();
      m_pc = rnp;
    end else begin
      if (rv && !empty) void'(m_q.pop_front());
      if (fire) begin
        m_q.push_back(pn);
        m_pc = pn;
      end
    end
    @(posedge clk); #1;
    chk("pc", pc, m_pc);
    chk("fifo_full", fifo_full, m_q.size() == 4);
    chk("res_err", res_err, m_err);
  endtask

  task automatic rand_run(input int n);
    bit          st, pt, rv, rb, rt, f, r, u, t;
    logic [31:0] rpc, rnp;
    for (int k = 0; k < n; k++) begin
      st  = ($urandom % 4) == 0;
      pt  = $urandom % 2;
      rv  = m_q.size() != 0 && ($urandom % 2);
      rb  = $urandom % 2;
      rt  = $urandom % 2;
      rpc = (($urandom % 3) == 0 ? 32'h40 : 32'h0) + ($urandom % 16) * 4;
      rnp = (rv && ($urandom % 4) != 0) ? m_q[0] : ($urandom % 96) * 4;
      step(st, pt, rv, rb, rt, rpc, rnp, f, r, u, t);
    end
  endtask

  typedef struct {
    bit          st, pt, rv, rb, rt;
    logic [31:0] rpc, rnp;
    bit          fire, redir, uv, ut;
    logic [31:0] pc_n;
    bit          full_n, err_n;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit st, pt, rv, rb, rt, logic [31:0] rpc, rnp,
                              bit fire, redir, uv, ut, logic [31:0] pc_n, bit full_n, err_n);
    vec_t v;
    v.st = st; v.pt = pt; v.rv = rv; v.rb = rb; v.rt = rt; v.rpc = rpc; v.rnp = rnp;
    v.fire = fire; v.redir = redir; v.uv = uv; v.ut = ut; v.pc_n = pc_n;
    v.full_n = full_n; v.err_n = err_n;
    tbl.push_back(v);
  endfunction

  initial begin
    bit f, r, u, t;
    mreset();
    // sequential fill to full, then hold
    add(0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h4,   0,0);
    add(0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h8,   0,0);
    add(0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'hC,   0,0);
    add(0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h10,  1,0);
    add(0,0,0,0,0, 32'h0,   32'h0,   0,0,0,0, 32'h10,  1,0);
    // pop while full: no push that cycle
    add(0,0,1,1,0, 32'h0,   32'h4,   0,0,1,0, 32'h10,  0,0);
    add(1,0,1,0,0, 32'h4,   32'h8,   0,0,0,0, 32'h10,  0,0);
    // taken branch at 0x8 to 0x40 mispredicts and trains the BTB
    add(0,0,1,1,1, 32'h8,   32'h40,  0,1,1,1, 32'h40,  0,0);
    add(0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h44,  0,0);
    add(0,0,1,0,0, 32'h3C,  32'h8,   0,1,0,0, 32'h8,   0,0);
    // fetch at 0x8 with pred_taken follows the BTB target
    add(0,1,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h40,  0,0);
    add(0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h44,  0,0);
    // stall plus mispredict: redirect wins
    add(1,0,1,1,1, 32'h8,   32'h100, 0,1,1,1, 32'h100, 0,0);
    // resolve with empty buffer: sticky error, pc unchanged
    add(1,0,1,0,0, 32'h200, 32'h300, 0,0,0,0, 32'h100, 0,1);
    add(0,0,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'h104, 0,1);
    // not-taken branch at 0x8 evicts its BTB entry
    add(0,0,1,1,0, 32'h8,   32'h104, 1,0,1,0, 32'h108, 0,1);
    add(0,0,1,0,0, 32'h104, 32'h8,   0,1,0,0, 32'h8,   0,1);
    add(0,1,0,0,0, 32'h0,   32'h0,   1,0,0,0, 32'hC,   0,1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_full", fifo_full, 1'b0);
    chk("reset_err", res_err, 1'b0);
    chk("reset_wrap_pc", w_pc, 32'hFFFF_FFFC);
    reset = 1'b0;
    w_stall = 1'b0;
    #2;
    chk("wrap_fire", w_fire, 1'b1);
    @(posedge clk); #1;
    w_stall = 1'b1;
    chk("wrap_pc", w_pc, 32'h0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].st, tbl[k].pt, tbl[k].rv, tbl[k].rb, tbl[k].rt, tbl[k].rpc, tbl[k].rnp, f, r, u, t);
      chk($sformatf("vec%0d_fire", k), f, tbl[k].fire);
      chk($sformatf("vec%0d_redirect", k), r, tbl[k].redir);
      chk($sformatf("vec%0d_upd_valid", k), u, tbl[k].uv);
      chk($sformatf("vec%0d_upd_taken", k), t, tbl[k].ut);
      chk($sformatf("vec%0d_pc", k), pc, tbl[k].pc_n);
      chk($sformatf("vec%0d_full", k), fifo_full, tbl[k].full_n);
      chk($sformatf("vec%0d_err", k), res_err, tbl[k].err_n);
    end

    rand_run(1500);

    // asynchronous reset mid-operation
    reset = 1'b1;
    #2;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_full", fifo_full, 1'b0);
    chk("async_reset_err", res_err, 1'b0);
    res_valid = 1'b1; res_is_branch = 1'b1; res_taken = 1'b1;
    #1;
    chk("reset_upd_valid", upd_valid, 1'b1);
    chk("reset_upd_taken", upd_taken, 1'b1);
    chk("reset_redirect", redirect, 1'b0);
    res_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset_hold_pc", pc, 32'h0);
    mreset();
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, f, r, u, t);
    chk("first_fetch_pc", pc, 32'h4);
    rand_run(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16: direct-mapped BTB depth, power of two.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: in-flight prediction buffer depth, power of two.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  downstream cannot accept a fetch this cycle.
REQ-007 SHALL have port pred_taken  input  1  direction prediction for current pc, from the gshare predictor.
REQ-008 SHALL have port pc  output  32  current fetch address, also drives the predictor pc input.
REQ-009 SHALL have port fetch_fire  output  1  fetch at pc accepted this cycle.
REQ-010 SHALL have port res_valid  input  1  one in-order resolved instruction.
REQ-011 SHALL have port res_is_branch  input  1  resolved instruction is a conditional branch.
REQ-012 SHALL have port res_taken  input  1  actual branch direction.
REQ-013 SHALL have port res_pc  input  32  address of resolved instruction.
REQ-014 SHALL have port res_next_pc  input  32  architecturally correct next address.
REQ-015 SHALL have port redirect  output  1  mispredict detected, younger fetches flushed.
REQ-016 SHALL have port upd_valid  output  1  predictor update strobe.
REQ-017 SHALL have port upd_taken  output  1  predictor actual_taken.
REQ-018 SHALL have port fifo_full  output  1  in-flight buffer full.
REQ-019 SHALL have port res_err  output  1  sticky: resolve seen with buffer empty.

Function
REQ-020 BTB entry SHALL hold valid, tag pc[31:2+log2(BTB_ENTRIES)], 32-bit target; index pc[1+log2(BTB_ENTRIES):2].
REQ-021 btb_hit SHALL be combinational: valid and tag match at pc.
REQ-022 Predicted next PC SHALL be btb target when pred_taken and btb_hit, else pc+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0).
REQ-023 fetch_fire SHALL equal !stall and !fifo_full and !redirect.
REQ-024 On fetch_fire, pc SHALL load predicted next PC at next edge and predicted next PC SHALL be pushed to FIFO tail; otherwise pc holds.
REQ-025 On res_valid with FIFO non-empty, head SHALL pop; mispredict iff head != res_next_pc.
REQ-026 redirect SHALL be combinational, asserted same cycle as mispredicting res_valid.
REQ-027 On redirect: FIFO flushed to empty (no push that cycle), pc loads res_next_pc at next edge; redirect has priority over fetch and stall.
REQ-028 upd_valid SHALL equal res_valid and res_is_branch, upd_taken = res_taken, same cycle, independent of redirect.
REQ-029 On res_valid, res_is_branch, res_taken: BTB entry for res_pc SHALL be written valid with tag and target res_next_pc at next edge.
REQ-030 On res_valid, res_is_branch, !res_taken: BTB entry for res_pc SHALL be invalidated only if its tag matches.
REQ-031 BTB write and same-cycle lookup of same index SHALL see old contents (no bypass).
REQ-032 Push and pop in same cycle SHALL keep occupancy unchanged; full and pop same cycle SHALL not permit push (fetch_fire uses registered full).
REQ-033 res_valid with FIFO empty SHALL be ignored except setting res_err; no redirect, no pop.
REQ-034 fifo_full SHALL be registered occupancy == FIFO_DEPTH.

Reset
REQ-035 While reset high: pc = RESET_PC, FIFO empty, fifo_full = 0, res_err = 0, all BTB valid = 0.
REQ-036 Reset asserted mid-operation SHALL discard in-flight entries and BTB contents immediately; outputs combinational from ports (redirect, upd_*) follow inputs.
REQ-037 First fetch SHALL occur on first edge after reset deasserts with stall = 0.

Verification
REQ-038 Sequential: reset, stall=0, pred_taken=0, no res -> pc 0,4,8,12 then holds at 16 with fifo_full=1.
REQ-039 Taken branch train: res at pc 0x8 branch taken, next 0x40 -> BTB written; later fetch at 0x8 with pred_taken=1 -> next pc 0x40.
REQ-040 Mispredict: fetches 0,4,8 buffered, res pc 0 next 0x100 -> redirect=1 same cycle, next pc 0x100, FIFO empty, upd_* per res_is_branch.
REQ-041 Simultaneous stall=1 and mispredict -> redirect wins, pc = res_next_pc next edge.
REQ-042 res_valid with empty FIFO -> res_err=1 sticky until reset, pc unchanged.
REQ-043 Wrap: RESET_PC=0xFFFF_FFFC, one fetch -> pc 0x0000_0000.
